// File: rtl/vga_reg_snapshot.sv
// vga_reg_snapshot: on each vertical sync start, reads five CPU registers
// through the register-file debug port (req/ack) into a shadow buffer and
// commits all 160 bits to the display bus in one edge, so the VGA text
// datapath never sees a half-updated register set.
module vga_reg_snapshot #(
  parameter logic [4:0] REG_BASE = 5'd1,
  parameter logic [7:0] TIMEOUT  = 8'd255
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         VS,
  input  logic         freeze,
  output logic         rf_req,
  output logic [4:0]   rf_addr,
  input  logic         rf_ack,
  input  logic [31:0]  rf_data,
  output logic [159:0] reg1to5,
  output logic         snap_valid,
  output logic [7:0]   frame_cnt,
  output logic         busy,
  output logic         err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     k_q, k_d, k_inc;
  logic [7:0]     tc_q, tc_d, tc_inc;
  logic           vs_q;
  logic           vs_fall;
  logic           rf_req_q, rf_req_d;
  logic [4:0]     rf_addr_q, rf_addr_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
  logic [159:0]   bus_q, bus_d;
  logic           snap_q, snap_d;
  logic [7:0]     fcnt_q, fcnt_d;
  logic           shadow_we;
  logic [31:0]    shadow_q [0:4];

  // VS is active-low; a start of vertical sync is a 1->0 transition
  assign vs_fall = vs_q & ~VS;
  assign k_inc   = k_q + 3'd1;
  assign tc_inc  = tc_q + 8'd1;

  assign rf_req     = rf_req_q;
  assign rf_addr    = rf_addr_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign reg1to5    = bus_q;
  assign snap_valid = snap_q;
  assign frame_cnt  = fcnt_q;

  // Next-state and next-output logic for the snapshot sequencer
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    tc_d      = tc_q;
    rf_req_d  = 1'b0;
    rf_addr_d = rf_addr_q;
    busy_d    = 1'b0;
    err_d     = 1'b0;
    bus_d     = bus_q;
    snap_d    = snap_q;
    fcnt_d    = fcnt_q;
    shadow_we = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // rf_ack is ignored here; only a VS start without freeze opens a read
        if (vs_fall && !freeze) begin
          state_d   = ST_REQ;
          k_d       = 3'd0;
          tc_d      = 8'd0;
          rf_req_d  = 1'b1;
          rf_addr_d = REG_BASE;
          busy_d    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        // A VS start here is deliberately dropped: no queuing across frames
        busy_d = 1'b1;
        if (rf_ack) begin
          shadow_we = 1'b1;
          tc_d      = 8'd0;
          if (k_q == 3'd4) begin
            state_d  = ST_COMMIT;
            rf_req_d = 1'b0;
          end else begin
            k_d       = k_inc;
            rf_req_d  = 1'b1;
            rf_addr_d = REG_BASE + {2'b00, k_inc};
          end
        end else begin
          if (tc_inc == TIMEOUT) begin
            // Give up on this frame; the partial shadow is never committed
            state_d  = ST_IDLE;
            err_d    = 1'b1;
            tc_d     = 8'd0;
            k_d      = 3'd0;
            rf_req_d = 1'b0;
            busy_d   = 1'b0;
          end else begin
            tc_d     = tc_inc;
            rf_req_d = 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        k_d     = 3'd0;
        // freeze sampled here also covers a freeze raised mid-sequence
        if (!freeze) begin
          bus_d  = {shadow_q[4], shadow_q[3], shadow_q[2], shadow_q[1], shadow_q[0]};
          snap_d = 1'b1;
          fcnt_d = fcnt_q + 8'd1;
        end else begin
          bus_d = bus_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        k_d     = 3'd0;
        tc_d    = 8'd0;
      end
    endcase
  end

  // Sequencer state and all registered outputs, cleared asynchronously
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      k_q       <= 3'd0;
      tc_q      <= 8'd0;
      vs_q      <= 1'b1;
      rf_req_q  <= 1'b0;
      rf_addr_q <= 5'd0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      bus_q     <= 160'd0;
      snap_q    <= 1'b0;
      fcnt_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      tc_q      <= tc_d;
      vs_q      <= VS;
      rf_req_q  <= rf_req_d;
      rf_addr_q <= rf_addr_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      bus_q     <= bus_d;
      snap_q    <= snap_d;
      fcnt_q    <= fcnt_d;
    end
  end

  // Shadow buffer capture; not reset because it is only read after a full refill
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 5; i++) begin
      if (shadow_we && (k_q == 3'(i))) begin
        shadow_q[i] <= rf_data;
      end
    end
  end

endmodule

// File: tb/tb_vga_reg_snapshot.sv
// Directed bench for vga_reg_snapshot: zero-wait and wait-state reads,
// timeout, freeze, extra VS, reset mid-sequence and frame counter wrap.
module tb_vga_reg_snapshot;

  logic         CLK = 1'b0;
  logic         RST;
  logic         VS;
  logic         freeze;
  logic         rf_req;
  logic [4:0]   rf_addr;
  logic         rf_ack;
  logic [31:0]  rf_data;
  logic [159:0] reg1to5;
  logic         snap_valid;
  logic [7:0]   frame_cnt;
  logic         busy;
  logic         err;

  localparam logic [159:0] BUS1 = {32'h00001005, 32'h00001004, 32'h00001003, 32'h00001002, 32'h00001001};
  localparam logic [159:0] BUS2 = {32'h00002005, 32'h00002004, 32'h00002003, 32'h00002002, 32'h00002001};
  localparam logic [159:0] BUS3 = {32'h00003005, 32'h00003004, 32'h00003003, 32'h00003002, 32'h00003001};
  localparam logic [159:0] BUS5 = {32'h00005005, 32'h00005004, 32'h00005003, 32'h00005002, 32'h00005001};
  localparam logic [159:0] BUS7 = {32'h00007005, 32'h00007004, 32'h00007003, 32'h00007002, 32'h00007001};

  vga_reg_snapshot #(.REG_BASE(5'd1), .TIMEOUT(8'd8)) dut (
    .CLK(CLK), .RST(RST), .VS(VS), .freeze(freeze),
    .rf_req(rf_req), .rf_addr(rf_addr), .rf_ack(rf_ack), .rf_data(rf_data),
    .reg1to5(reg1to5), .snap_valid(snap_valid), .frame_cnt(frame_cnt),
    .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;

  int          n_total = 0;
  int          n_bad   = 0;
  int          wait_n;
  bit          stuck;
  bit          idle_ack;
  logic [31:0] data_base;
  int          wcnt;
  logic [4:0]  last_addr;
  int          req_seen, err_seen, ack_seen, addr_jumps;
  logic [4:0]  addr_log [$];

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample just after the edge, then let the register-file model answer
  task automatic tick();
    @(posedge CLK);
    #1;
    if (rf_req) req_seen++;
    if (err) err_seen++;
    if (rf_req && !stuck) begin
      if (wcnt > 0 && rf_addr !== last_addr) addr_jumps++;
      last_addr = rf_addr;
      if (wcnt == wait_n) begin
        rf_ack  = 1'b1;
        rf_data = {27'h0, rf_addr} + data_base;
        wcnt    = 0;
        ack_seen++;
        addr_log.push_back(rf_addr);
      end else begin
        rf_ack  = 1'b0;
        rf_data = 32'hDEADBEEF;
        wcnt++;
      end
    end else begin
      rf_ack  = idle_ack;
      rf_data = 32'hBADBAD00;
      wcnt    = 0;
    end
  endtask

  // The edge inside this task is E0
  task automatic vs_pulse();
    VS = 1'b0;
    tick();
    VS = 1'b1;
  endtask

  task automatic clear_counts();
    req_seen   = 0;
    err_seen   = 0;
    ack_seen   = 0;
    addr_jumps = 0;
    addr_log.delete();
  endtask

  initial begin
    RST = 1'b1; VS = 1'b1; freeze = 1'b0; rf_ack = 1'b0; rf_data = 32'h0;
    wait_n = 0; stuck = 1'b0; idle_ack = 1'b0; data_base = 32'h1000; wcnt = 0;
    last_addr = 5'd0;
    clear_counts();
    repeat (3) @(posedge CLK);
    #1;
    check("rst_req", rf_req, 1'b0);
    check("rst_addr", rf_addr, 5'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_bus", reg1to5, 160'd0);
    check("rst_valid", snap_valid, 1'b0);
    check("rst_fcnt", frame_cnt, 8'd0);
    RST = 1'b0;
    repeat (2) tick();

    // Zero-wait reads
    clear_counts(); data_base = 32'h1000; wait_n = 0;
    vs_pulse();
    check("e0_busy", busy, 1'b1);
    check("e0_req", rf_req, 1'b1);
    check("e0_addr", rf_addr, 5'd1);
    repeat (5) tick();
    check("e5_bus_hold", reg1to5, 160'd0);
    tick();
    check("e6_bus", reg1to5, BUS1);
    check("e6_fcnt", frame_cnt, 8'd1);
    check("e6_valid", snap_valid, 1'b1);
    check("e6_busy", busy, 1'b0);
    check("zw_acks", ack_seen, 5);
    check("zw_addr_cnt", addr_log.size(), 5);
    for (int i = 0; i < addr_log.size() && i < 5; i++) check("zw_addr_seq", addr_log[i], 5'(i + 1));
    repeat (3) tick();

    // Three wait states per word
    clear_counts(); data_base = 32'h2000; wait_n = 3;
    vs_pulse();
    repeat (20) tick();
    check("ws_bus_hold", reg1to5, BUS1);
    tick();
    check("ws_bus", reg1to5, BUS2);
    check("ws_fcnt", frame_cnt, 8'd2);
    check("ws_addr_stable", addr_jumps, 0);
    check("ws_acks", ack_seen, 5);
    repeat (3) tick();
    wait_n = 0;

    // Timeout with ack stuck low, then a retry
    clear_counts(); stuck = 1'b1;
    vs_pulse();
    repeat (11) tick();
    check("to_err_pulses", err_seen, 1);
    check("to_req_cycles", req_seen, 8);
    check("to_bus", reg1to5, BUS2);
    check("to_fcnt", frame_cnt, 8'd2);
    check("to_busy", busy, 1'b0);
    stuck = 1'b0;
    clear_counts(); data_base = 32'h3000;
    vs_pulse();
    repeat (6) tick();
    check("retry_bus", reg1to5, BUS3);
    check("retry_fcnt", frame_cnt, 8'd3);

    // Freeze at VS start
    clear_counts(); freeze = 1'b1;
    vs_pulse();
    repeat (8) tick();
    check("frz_no_req", req_seen, 0);
    check("frz_fcnt", frame_cnt, 8'd3);
    freeze = 1'b0;

    // Freeze raised after word 2
    clear_counts(); data_base = 32'h4000;
    vs_pulse();
    repeat (3) tick();
    freeze = 1'b1;
    repeat (6) tick();
    check("frzmid_acks", ack_seen, 5);
    check("frzmid_bus", reg1to5, BUS3);
    check("frzmid_fcnt", frame_cnt, 8'd3);
    check("frzmid_busy", busy, 1'b0);
    freeze = 1'b0;
    tick();

    // Second VS start during REQ, with stray acks while idle
    clear_counts(); data_base = 32'h5000; idle_ack = 1'b1;
    vs_pulse();
    tick();
    VS = 1'b0;
    tick();
    VS = 1'b1;
    repeat (10) tick();
    check("xvs_acks", ack_seen, 5);
    check("xvs_fcnt", frame_cnt, 8'd4);
    check("xvs_bus", reg1to5, BUS5);
    idle_ack = 1'b0;
    tick();

    // Reset with k=3
    clear_counts(); data_base = 32'h6000;
    vs_pulse();
    repeat (3) tick();
    check("mid_addr_k3", rf_addr, 5'd4);
    RST = 1'b1;
    #1;
    check("mrst_req", rf_req, 1'b0);
    check("mrst_addr", rf_addr, 5'd0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_err", err, 1'b0);
    check("mrst_bus", reg1to5, 160'd0);
    check("mrst_valid", snap_valid, 1'b0);
    check("mrst_fcnt", frame_cnt, 8'd0);
    repeat (2) tick();
    RST = 1'b0;
    clear_counts();
    repeat (10) tick();
    check("post_rst_fcnt", frame_cnt, 8'd0);
    check("post_rst_bus", reg1to5, 160'd0);
    check("post_rst_valid", snap_valid, 1'b0);
    check("post_rst_err", err_seen, 0);

    // Frame counter wrap
    data_base = 32'h7000;
    for (int f = 0; f < 255; f++) begin
      vs_pulse();
      repeat (7) tick();
    end
    check("wrap_255", frame_cnt, 8'd255);
    vs_pulse();
    repeat (7) tick();
    check("wrap_0", frame_cnt, 8'd0);
    check("wrap_valid", snap_valid, 1'b1);
    check("wrap_bus", reg1to5, BUS7);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
